// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared types and sizing constants for the register dump path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   REG_DUMP_NREGS  default register count (power of two)
//   REG_DUMP_DW     default register data width
//   dump_state_t    sequencer states IDLE, READ, SEND, DONE
//   dump_span_len   number of entries in an inclusive, wrapping index range
package reg_dump_pkg;

  localparam int REG_DUMP_NREGS = 16;
  localparam int REG_DUMP_DW    = 8;

  // Fixed encodings so the state is easy to read off a probe or a dump.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

  // Inclusive span from first to last, wrapping through the top index.
  // The AW-bit subtraction already wraps mod NREGS; one extra bit holds the
  // full-range result (first == last + 1 gives NREGS entries).
  function automatic logic [4:0] dump_span_len(input logic [3:0] first_idx,
                                               input logic [3:0] last_idx);
    logic [3:0] diff;
    diff = last_idx - first_idx;
    return {1'b0, diff} + 5'd1;
  endfunction

endpackage

// File: rtl/reg_dump_unit_wrap_counter.sv
// wrap_counter: index pointer that walks an inclusive range mod NREGS plus a
// remaining-entry count. Latency: load/incr take effect at the next edge.
// Backpressure: none of its own; the owner only pulses incr on a completed beat.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   load          capture load_first/load_last and compute the entry count
//   load_first    first index of the range
//   load_last     last index of the range, inclusive
//   incr          advance pointer (wraps NREGS-1 -> 0) and consume one entry
//   ptr           current index
//   exhausted     the entry at ptr is the final one of the range
module wrap_counter
  import reg_dump_pkg::*;
#(
  parameter int NREGS = REG_DUMP_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_first,
  input  logic [AW-1:0] load_last,
  input  logic          incr,
  output logic [AW-1:0] ptr,
  output logic          exhausted
);

  // One bit wider than the index so a full wrap (NREGS entries) fits.
  logic [AW:0]   remaining;
  logic [AW-1:0] end_idx;
  logic [AW-1:0] span;

  // Subtraction in AW bits wraps mod NREGS because NREGS is a power of two.
  assign span = load_last - load_first;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      remaining <= '0;
      end_idx   <= '0;
    end else if (load) begin
      ptr       <= load_first;
      end_idx   <= load_last;
      remaining <= {1'b0, span} + (AW+1)'(1);
    end else if (incr) begin
      ptr       <= ptr + 1'b1;
      remaining <= remaining - (AW+1)'(1);
    end
  end

  assign exhausted = (remaining == (AW+1)'(1));

  // The count and the stored end index are two views of the same range;
  // they must agree whenever the count says this is the last entry.
  a_end_agrees: assert property (@(posedge clk) disable iff (rst)
    exhausted |-> (ptr == end_idx));

  // Incrementing with nothing left would walk past the requested range.
  a_no_overrun: assert property (@(posedge clk) disable iff (rst)
    incr |-> (remaining > (AW+1)'(1)));

endmodule

// File: rtl/reg_dump_unit.sv
// reg_dump_unit: walks a wrapping register-index range, reads each byte via rf_sel
// and streams (index, byte) beats. Latency: first beat 2 cycles after start, 2 cycles/beat.
// Backpressure: out_ready low stalls in SEND with out_data/out_addr/out_last held.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begin a dump (ignored while busy); samples first/last
//   first, last       inclusive index range; last < first wraps through NREGS-1
//   busy              dump in progress, from the cycle after start through DONE
//   rf_sel, rf_data   register file read port (rf_data combinational from rf_sel)
//   out_valid/ready   stream handshake
//   out_data/addr     captured byte and its index
//   out_last          final beat of the dump
//   done              one-cycle pulse after the final beat is accepted
//
// Build option REG_DUMP_CHECKSUM_EN: append one beat with out_addr all ones
// carrying the mod-2^DW sum of the dumped bytes; out_last moves to that beat.
module reg_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int NREGS = REG_DUMP_NREGS,
  parameter int DW    = REG_DUMP_DW,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  output logic          busy,
  output logic [AW-1:0] rf_sel,
  input  logic [DW-1:0] rf_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          done
);

  dump_state_t   state;
  logic [AW-1:0] ptr;
  logic          exhausted;
  logic          accept;
  logic          beat_done;
  logic          incr;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DW-1:0] sum;
  // Set while the trailing checksum beat is on the stream.
  logic          csum_beat;
`endif

  assign accept    = (state == IDLE) && start;
  assign beat_done = (state == SEND) && out_ready;

  // The pointer only moves between register beats; it stays on the final
  // index afterwards so rf_sel holds its last value while idle.
`ifdef REG_DUMP_CHECKSUM_EN
  assign incr = beat_done && !exhausted && !csum_beat;
`else
  assign incr = beat_done && !exhausted;
`endif

  wrap_counter #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_wrap_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_first (first),
    .load_last  (last),
    .incr       (incr),
    .ptr        (ptr),
    .exhausted  (exhausted)
  );

  assign rf_sel = ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      sum       <= '0;
      csum_beat <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= READ;
            busy  <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            sum       <= '0;
            csum_beat <= 1'b0;
`endif
          end
        end

        READ: begin
          // rf_sel has been steady on ptr for this whole cycle.
          out_data  <= rf_data;
          out_addr  <= ptr;
          out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
          sum       <= sum + rf_data;
`else
          out_last  <= exhausted;
`endif
          state     <= SEND;
        end

        SEND: begin
          if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
            if (csum_beat) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              csum_beat <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else if (exhausted) begin
              // Stay in SEND and swap the checksum onto the stream; sum
              // already includes the byte captured for this final beat.
              out_data  <= sum;
              out_addr  <= '1;
              out_last  <= 1'b1;
              csum_beat <= 1'b1;
            end else begin
              out_valid <= 1'b0;
              state     <= READ;
            end
`else
            if (exhausted) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              out_valid <= 1'b0;
              state     <= READ;
            end
`endif
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // A stalled beat must not change under the consumer.
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_data) && $stable(out_addr) && $stable(out_last)));

  a_done_single: assert property (@(posedge clk) disable iff (rst)
    done |=> !done);

  a_last_needs_valid: assert property (@(posedge clk) disable iff (rst)
    out_last |-> out_valid);

  a_valid_only_send: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (state == SEND));

endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit: randomized scoreboard bench for reg_dump_unit.
// Latency: beat timing checked when out_ready is held high.
// Backpressure: out_ready driven high, random, or stalled on a chosen beat.
module tb_reg_dump_unit;

  localparam int NREGS = 16;
  localparam int DW    = 8;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] first;
  logic [AW-1:0] last;
  logic          busy;
  logic [AW-1:0] rf_sel;
  logic [DW-1:0] rf_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          done;

  always #5 clk = ~clk;

  // Register file beside the DUT: combinational read port.
  logic [DW-1:0] rf_mem [NREGS];
  assign rf_data = rf_mem[rf_sel];

  reg_dump_unit #(.NREGS(NREGS), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .first     (first),
    .last      (last),
    .busy      (busy),
    .rf_sel    (rf_sel),
    .rf_data   (rf_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .done      (done)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] addr;
    logic       lst;
    logic       fin;
    int         cyc;   // expected sampling cycle, -1 when not timed
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int hs_count = 0;
  int done_due = -1;
  int done_cnt = 0;
  int rdy_mode = 0;
  int stall_beat = 0;
  int stall_left = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: list the beats the dump must produce, straight from the
  // range rules, and queue them.
  task automatic push_dump(input int f, input int l, input int acc, input bit timed);
    int n;
    int s;
    n = ((l - f) % NREGS + NREGS) % NREGS + 1;
    s = 0;
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.addr = 4'((f + k) % NREGS);
      b.data = rf_mem[(f + k) % NREGS];
      s += int'(b.data);
`ifdef REG_DUMP_CHECKSUM_EN
      b.lst = 1'b0;
      b.fin = 1'b0;
`else
      b.lst = (k == n - 1);
      b.fin = (k == n - 1);
`endif
      b.cyc = timed ? acc + 1 + 2 * k : -1;
      sb.push_back(b);
    end
`ifdef REG_DUMP_CHECKSUM_EN
    begin
      beat_t c;
      c.addr = 4'hF;
      c.data = 8'(s % 256);
      c.lst  = 1'b1;
      c.fin  = 1'b1;
      c.cyc  = timed ? acc + 2 * n : -1;
      sb.push_back(c);
    end
`endif
  endtask

  // Monitor: samples on the falling edge, pops on every handshake.
  logic       hold_p = 1'b0;
  logic [7:0] hd;
  logic [3:0] ha;
  logic       hl;

  always @(negedge clk) begin
    if (rst) begin
      hold_p = 1'b0;
    end else begin
      if (hold_p) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hd);
        check("hold_addr", out_addr, ha);
        check("hold_last", out_last, hl);
      end
      if (out_last) check("last_needs_valid", out_valid, 1);
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: addr 0x%0h data 0x%0h with empty scoreboard (cycle %0d)",
                   out_addr, out_data, cyc);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("beat_data", out_data, e.data);
          check("beat_addr", out_addr, e.addr);
          check("beat_last", out_last, e.lst);
          if (e.cyc >= 0) check("beat_cycle", cyc, e.cyc);
          if (e.fin) done_due = cyc + 1;
        end
        hs_count++;
      end
      if (done) begin
        check("done_cycle", cyc, done_due);
        done_cnt++;
        done_due = -1;
      end else if (done_due == cyc) begin
        check("done_missing", done, 1);
        done_due = -1;
      end
      hold_p = out_valid && !out_ready;
      hd = out_data;
      ha = out_addr;
      hl = out_last;
    end
  end

  // Consumer ready: 0 = always, 1 = random, 2 = stall a chosen beat.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (out_valid && hs_count == stall_beat && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_dump(input int f, input int l, input bit timed);
    int acc;
    check("idle_before_start", busy, 0);
    first = 4'(f);
    last  = 4'(l);
    start = 1'b1;
    acc   = cyc + 1;
    hs_count = 0;
    push_dump(f, l, acc, timed);
    tick();
    start = 1'b0;
    first = 4'($urandom);
    last  = 4'($urandom);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 600) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
      sb.delete();
    end else begin
      check("sb_drained", sb.size(), 0);
      tick();
      check("busy_fall", busy, 0);
      check("done_one_cycle", done, 0);
    end
  endtask

  task automatic randomize_rf();
    for (int i = 0; i < NREGS; i++) rf_mem[i] = 8'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1);
  end

  initial begin
    int n;
    int d0;
    rst = 1'b1;
    start = 1'b0;
    first = '0;
    last = '0;
    out_ready = 1'b1;
    randomize_rf();
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_rf_sel", rf_sel, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
    rst = 1'b0;
    tick();

    // Known bytes in r0..r3, straight run with the consumer always ready.
    rf_mem[0] = 8'h11;
    rf_mem[1] = 8'h22;
    rf_mem[2] = 8'h33;
    rf_mem[3] = 8'h44;
    rdy_mode = 0;
    begin_dump(0, 3, 1);
    wait_done();

    // Same range, beat 2 stalled for three cycles.
    rdy_mode = 2;
    stall_beat = 1;
    stall_left = 3;
    begin_dump(0, 3, 0);
    wait_done();
    rdy_mode = 0;

    // Wrapping range 14,15,0,1.
    begin_dump(14, 1, 1);
    wait_done();

    // Single register.
    begin_dump(9, 9, 1);
    wait_done();

    // A second start during beat 1 must be ignored.
    begin_dump(0, 3, 1);
    tick();
    check("busy_during_beat1", busy, 1);
    first = 4'd5;
    last  = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();

    // Reset during the SEND of beat 2 abandons the dump without done.
    rdy_mode = 2;
    stall_beat = 1;
    stall_left = 1000;
    begin_dump(0, 3, 0);
    n = 0;
    while (!(out_valid && hs_count == 1) && n < 50) begin
      tick();
      n++;
    end
    check("reached_beat2", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    sb.delete();
    done_due = -1;
    d0 = done_cnt;
    repeat (20) tick();
    check("no_done_after_rst", done_cnt, d0);
    rdy_mode = 0;
    stall_left = 0;

    // Randomized ranges, contents and backpressure.
    for (int it = 0; it < 24; it++) begin
      randomize_rf();
      rdy_mode = 1;
      begin_dump($urandom_range(0, 15), $urandom_range(0, 15), 0);
      wait_done();
    end

    // Full 16-entry wrap with the consumer always ready: last beat at cycle 32.
    rdy_mode = 0;
    randomize_rf();
    begin_dump(3, 2, 1);
    wait_done();

    repeat (5) tick();
    check("sb_empty_at_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
